// File: rtl/reg_spill.sv
// rtl/reg_spill.sv - register file dump/load engine between a register file and a word stream
//
// Purpose:
//   Moves the whole register file (N = 1<<REG_BIT_CNT words) out to a
//   ready/valid output stream (dump, mode=0) or fills it from a ready/valid
//   input stream (load, mode=1). One transfer per start; abort cancels.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, mode, abort    transfer request, type (0 dump / 1 load), cancel
//   busy, done            not-idle flag, one-cycle completion pulse
//   rf_we, rf_acc         register file write enable / write data
//   rf_reg_select         register file read/write select
//   rf_data_in            combinational register file read data
//   m_valid/m_data/m_ready  dump output stream
//   s_valid/s_data/s_ready  load input stream
module reg_spill #(
  parameter int DATA_WIDTH  = 8,
  parameter int REG_BIT_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   rf_we,
  output logic [DATA_WIDTH-1:0]  rf_acc,
  output logic [REG_BIT_CNT-1:0] rf_reg_select,
  input  logic [DATA_WIDTH-1:0]  rf_data_in,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready
);

  localparam logic [REG_BIT_CNT-1:0] LAST_IDX = '1;
  localparam logic [REG_BIT_CNT-1:0] IDX_ONE  = REG_BIT_CNT'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DUMP_RD  = 3'd1,
    DUMP_OUT = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [REG_BIT_CNT-1:0] idx;
  logic [REG_BIT_CNT-1:0] idx_nxt;
  logic                   m_valid_nxt;
  logic [DATA_WIDTH-1:0]  m_data_nxt;
  logic                   last;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      m_valid <= m_valid_nxt;
      m_data  <= m_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    m_valid_nxt   = m_valid;
    m_data_nxt    = m_data;
    busy          = (state != IDLE);
    done          = (state == DONE);
    rf_we         = 1'b0;
    rf_acc        = '0;
    rf_reg_select = '0;
    s_ready       = 1'b0;

    case (state)
      IDLE: begin
        // abort outranks start even when nothing is running
        if (start && !abort) begin
          idx_nxt   = '0;
          state_nxt = mode ? LOAD : DUMP_RD;
        end
      end

      DUMP_RD: begin
        // read data is combinational, so one cycle is enough to capture it
        rf_reg_select = idx;
        m_data_nxt    = rf_data_in;
        m_valid_nxt   = 1'b1;
        state_nxt     = DUMP_OUT;
      end

      DUMP_OUT: begin
        rf_reg_select = idx;
        if (m_ready) begin
          m_valid_nxt = 1'b0;
          if (last) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + IDX_ONE;
            state_nxt = DUMP_RD;
          end
        end
      end

      LOAD: begin
        rf_reg_select = idx;
        rf_acc        = s_data;
        s_ready       = !abort;
        rf_we         = s_valid && !abort;
        if (s_valid) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + IDX_ONE;
          end
        end
      end

      DONE: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end

      default: begin
        idx_nxt     = '0;
        m_valid_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase

    // abort overrides every transition above; m_data keeps its old value
    if (abort && (state != IDLE)) begin
      state_nxt   = IDLE;
      idx_nxt     = '0;
      m_valid_nxt = 1'b0;
      m_data_nxt  = m_data;
    end
  end

endmodule

// File: tb/tb_reg_spill.sv
// tb/tb_reg_spill.sv - randomized and directed self-checking bench for reg_spill
module tb_reg_spill;

  localparam int DW = 8;
  localparam int RB = 3;
  localparam int N  = 1 << RB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          busy;
  logic          done;
  logic          rf_we;
  logic [DW-1:0] rf_acc;
  logic [RB-1:0] rf_reg_select;
  logic [DW-1:0] rf_data_in;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          s_ready;

  logic [DW-1:0] phys_rf [N];
  logic [DW-1:0] exp_rf  [N];

  int errors = 0;
  int checks = 0;

  reg_spill #(.DATA_WIDTH(DW), .REG_BIT_CNT(RB)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .rf_we(rf_we), .rf_acc(rf_acc),
    .rf_reg_select(rf_reg_select), .rf_data_in(rf_data_in),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  assign rf_data_in = phys_rf[rf_reg_select];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // register file written by the DUT
  initial forever begin
    @(posedge clk);
    if (rf_we) phys_rf[rf_reg_select] = rf_acc;
  end

  // transaction-level model: op 0 idle, 1 dump, 2 load, 3 done pulse;
  // k = words finished in this op, shown = dump word currently on the stream
  int op = 0;
  int k = 0;
  bit shown = 1'b0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      op = 0; k = 0; shown = 1'b0;
    end else if (op == 0) begin
      if (start && !abort) begin
        op = mode ? 2 : 1; k = 0; shown = 1'b0;
      end
    end else if (abort) begin
      op = 0; k = 0; shown = 1'b0;
    end else if (op == 3) begin
      op = 0;
    end else if (op == 1) begin
      if (!shown) shown = 1'b1;
      else if (m_ready) begin
        shown = 1'b0;
        if (k == N - 1) op = 3; else k++;
      end
    end else begin
      if (s_valid) begin
        exp_rf[k] = s_data;
        if (k == N - 1) op = 3; else k++;
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_acc", rf_acc, 0);
      chk("rst_sel", rf_reg_select, 0);
      chk("rst_s_ready", s_ready, 0);
    end else begin
      chk("busy", busy, op != 0);
      chk("done", done, op == 3);
      chk("m_valid", m_valid, (op == 1) && shown);
      if ((op == 1) && shown) chk("m_data", m_data, exp_rf[k]);
      chk("rf_reg_select", rf_reg_select, (op == 1 || op == 2) ? k : 0);
      chk("s_ready", s_ready, (op == 2) && !abort);
      chk("rf_we", rf_we, (op == 2) && s_valid && !abort);
      chk("rf_acc", rf_acc, (op == 2) ? s_data : 0);
    end
  end

  // event log for directed checks (cycle index counted at negedge)
  int            ncyc = 0;
  logic [DW-1:0] dq [$];
  int            dcyc [$];
  logic [RB-1:0] wsel [$];
  logic [DW-1:0] wacc [$];
  int            wcyc [$];
  int            done_cyc [$];
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (m_valid && m_ready && !rst) begin dq.push_back(m_data); dcyc.push_back(ncyc); end
    if (rf_we) begin wsel.push_back(rf_reg_select); wacc.push_back(rf_acc); wcyc.push_back(ncyc); end
    if (done) done_cyc.push_back(ncyc);
  end

  task automatic clear_logs();
    dq.delete(); dcyc.delete(); wsel.delete(); wacc.delete(); wcyc.delete(); done_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      if (!busy) break;
      tick();
    end
    chk({name, "_timeout"}, busy, 0);
  endtask

  task automatic go(input logic md);
    start = 1'b1; mode = md;
    tick();
    start = 1'b0;
  endtask

  // drive a load; s_valid high every (gap+1)th cycle, abort on handshake abort_at
  task automatic run_load(input int gap, input int abort_at, input logic [DW-1:0] base);
    int kk = 0;
    int c = 0;
    int t;
    clear_logs();
    go(1'b1);
    for (t = 0; t < 100 && busy; t++) begin
      s_valid = ((c % (gap + 1)) == 0);
      c++;
      s_data = base + DW'(kk);
      abort = (abort_at == kk) && s_valid;
      @(negedge clk);
      if (s_valid && s_ready) kk++;
      tick();
    end
    s_valid = 1'b0; abort = 1'b0;
    chk("load_timeout", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      phys_rf[i] = DW'(8'h10 + i);
      exp_rf[i]  = DW'(8'h10 + i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_data_literal", m_data, 8'h00);
    chk("reset_busy_literal", busy, 0);
    rst = 1'b0;
    tick();

    // dump at full rate
    clear_logs();
    m_ready = 1'b1;
    go(1'b0);
    wait_idle("dump1", 60);
    chk("dump1_count", dq.size(), N);
    for (int i = 0; i < N && i < dq.size(); i++) chk("dump1_word", dq[i], 8'h10 + i);
    for (int i = 1; i < N && i < dcyc.size(); i++) chk("dump1_spacing", dcyc[i] - dcyc[i-1], 2);
    chk("dump1_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && dcyc.size() == N) chk("dump1_done_lag", done_cyc[0] - dcyc[N-1], 1);

    // dump with 5 cycles of backpressure on word 3
    clear_logs();
    m_ready = 1'b1;
    go(1'b0);
    begin
      int t;
      for (t = 0; t < 40; t++) begin
        if (m_valid && m_data == 8'h13) break;
        tick();
      end
      chk("bp_found_word3", m_valid && (m_data == 8'h13), 1);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_data", m_data, 8'h13);
      tick();
    end
    m_ready = 1'b1;
    wait_idle("bp", 60);
    chk("bp_count", dq.size(), N);
    for (int i = 0; i < N && i < dq.size(); i++) chk("bp_word", dq[i], 8'h10 + i);

    // continuous load
    run_load(0, -1, 8'hA0);
    chk("load_we_count", wsel.size(), N);
    for (int i = 0; i < N && i < wsel.size(); i++) begin
      chk("load_sel", wsel[i], i);
      chk("load_acc", wacc[i], 8'hA0 + i);
      if (i > 0) chk("load_back_to_back", wcyc[i] - wcyc[i-1], 1);
    end
    chk("load_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && wcyc.size() == N) chk("load_done_lag", done_cyc[0] - wcyc[N-1], 1);
    for (int i = 0; i < N; i++) chk("load_rf", phys_rf[i], 8'hA0 + i);

    // gapped load 1,0,0,...
    run_load(2, -1, 8'h50);
    chk("gap_we_count", wsel.size(), N);
    for (int i = 1; i < N && i < wcyc.size(); i++) chk("gap_spacing", wcyc[i] - wcyc[i-1], 3);
    for (int i = 0; i < N && i < wsel.size(); i++) chk("gap_sel", wsel[i], i);
    chk("gap_done_count", done_cyc.size(), 1);
    for (int i = 0; i < N; i++) chk("gap_rf", phys_rf[i], 8'h50 + i);

    // abort on the 4th load handshake, then dump from index 0
    run_load(0, 3, 8'hC0);
    chk("abort_writes", wsel.size(), 3);
    chk("abort_no_done", done_cyc.size(), 0);
    chk("abort_idle", busy, 0);
    clear_logs();
    m_ready = 1'b1;
    go(1'b0);
    wait_idle("post_abort_dump", 60);
    chk("post_abort_count", dq.size(), N);
    if (dq.size() == N) begin
      chk("post_abort_w0", dq[0], 8'hC0);
      chk("post_abort_w2", dq[2], 8'hC2);
      chk("post_abort_w3", dq[3], 8'h53);
    end

    // asynchronous reset while in DUMP_OUT
    clear_logs();
    m_ready = 1'b0;
    go(1'b0);
    tick();
    chk("arst_pre_valid", m_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    chk("arst_stays_idle", busy, 0);
    chk("arst_no_writes", wsel.size(), 0);
    chk("arst_no_done", done_cyc.size(), 0);

    // start while busy and start during DONE are ignored
    clear_logs();
    m_ready = 1'b1;
    go(1'b0);
    repeat (3) tick();
    go(1'b1);
    begin
      int t;
      for (t = 0; t < 60; t++) begin
        if (done) break;
        tick();
      end
      chk("ign_reach_done", done, 1);
    end
    go(1'b1);
    chk("ign_start_in_done", busy, 0);
    chk("ign_dump_count", dq.size(), N);
    chk("ign_no_writes", wsel.size(), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start   = ($urandom_range(0, 7) == 0);
      mode    = 1'($urandom_range(0, 1));
      abort   = ($urandom_range(0, 49) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = DW'($urandom);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; rst = 1'b0; m_ready = 1'b1;
    repeat (40) tick();
    chk("final_idle", busy, 0);
    for (int i = 0; i < N; i++) chk("final_rf", phys_rf[i], exp_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
